// File: rtl/adder_tree_pkg.sv
// Sizing helpers and defaults shared by the adder tree top and its level sub-module.
package adder_tree_pkg;

    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_INPUT_NUM = 8;
    localparam int ACC_MARGIN        = 8;

    // Number of tree levels; never below one so a two-operand tree still registers once.
    function automatic int tree_stages(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int sum_width(input int w, input int n);
        return w + tree_stages(n);
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered reduction level: pairwise sums one bit wider, odd operand passes through extended.
module adder_tree_level
    import adder_tree_pkg::*;
#(
    parameter int IN_NUM   = 2,
    parameter int IN_WIDTH = 8,
    parameter int SIGNED   = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en_i,
    input  logic                                  valid_i,
    input  logic                                  last_i,
    input  logic [IN_NUM-1:0][IN_WIDTH-1:0]       data_i,
    output logic                                  valid_o,
    output logic                                  last_o,
    output logic [(IN_NUM+1)/2-1:0][IN_WIDTH:0]   data_o
);

    localparam int OUT_NUM = (IN_NUM + 1) / 2;

    logic [OUT_NUM-1:0][IN_WIDTH:0] data_d;
    logic [OUT_NUM-1:0][IN_WIDTH:0] data_q;
    logic                           valid_q;
    logic                           last_q;

    function automatic logic [IN_WIDTH:0] extend(input logic [IN_WIDTH-1:0] x);
        return (SIGNED != 0) ? {x[IN_WIDTH-1], x} : {1'b0, x};
    endfunction

    for (genvar i = 0; i < OUT_NUM; i++) begin : g_pair
        if (2 * i + 1 < IN_NUM) begin : g_add
            assign data_d[i] = extend(data_i[2*i]) + extend(data_i[2*i+1]);
        end else begin : g_pass
            assign data_d[i] = extend(data_i[2*i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (en_i) begin
            data_q  <= data_d;
            valid_q <= valid_i;
            last_q  <= last_i;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;

endmodule

// File: rtl/pipelined_adder_tree.sv
// Fully pipelined adder tree with optional multi-beat accumulation; one global stall covers every stage.
module pipelined_adder_tree
    import adder_tree_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int INPUT_NUM = DEFAULT_INPUT_NUM,
    parameter int SIGNED    = 1,
    parameter int ACC_WIDTH = sum_width(WIDTH, INPUT_NUM) + ACC_MARGIN
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                in_last,
    input  logic [INPUT_NUM-1:0][WIDTH-1:0]     indata,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [ACC_WIDTH-1:0]                res
);

    localparam int STAGE_NUM = tree_stages(INPUT_NUM);
    localparam int SUM_WIDTH = sum_width(WIDTH, INPUT_NUM);
    localparam int PAD_NUM   = 1 << STAGE_NUM;

    if (INPUT_NUM < 2) begin : g_chk_input_num
        $error("pipelined_adder_tree: INPUT_NUM must be at least 2");
    end
    if (ACC_WIDTH < SUM_WIDTH) begin : g_chk_acc_width
        $error("pipelined_adder_tree: ACC_WIDTH must not be narrower than the tree sum");
    end

    logic                              advance;
    logic [PAD_NUM-1:0][WIDTH-1:0]     padded;
    logic                              tree_valid;
    logic                              tree_last;
    logic [SUM_WIDTH-1:0]              tree_sum;
    logic [ACC_WIDTH-1:0]              sum_ext;
    logic [ACC_WIDTH-1:0]              total;
    logic [ACC_WIDTH-1:0]              acc_q;
    logic [ACC_WIDTH-1:0]              res_q;
    logic                              first_q;
    logic                              out_valid_q;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    always_comb begin
        padded                = '0;
        padded[INPUT_NUM-1:0] = indata;
    end

    // Level k consumes the previous level's output; widths grow by one bit per level.
    for (genvar k = 0; k < STAGE_NUM; k++) begin : g_lvl
        localparam int N_IN  = PAD_NUM >> k;
        localparam int N_OUT = (N_IN + 1) / 2;
        localparam int W_IN  = WIDTH + k;

        logic [N_IN-1:0][W_IN-1:0]  din;
        logic                       din_valid;
        logic                       din_last;
        logic [N_OUT-1:0][W_IN:0]   dout;
        logic                       dout_valid;
        logic                       dout_last;

        if (k == 0) begin : g_src
            assign din       = padded;
            assign din_valid = in_valid;
            assign din_last  = in_last;
        end else begin : g_src
            assign din       = g_lvl[k-1].dout;
            assign din_valid = g_lvl[k-1].dout_valid;
            assign din_last  = g_lvl[k-1].dout_last;
        end

        adder_tree_level #(
            .IN_NUM   (N_IN),
            .IN_WIDTH (W_IN),
            .SIGNED   (SIGNED)
        ) u_level (
            .clk     (clk),
            .rst     (rst),
            .en_i    (advance),
            .valid_i (din_valid),
            .last_i  (din_last),
            .data_i  (din),
            .valid_o (dout_valid),
            .last_o  (dout_last),
            .data_o  (dout)
        );
    end

    assign tree_valid = g_lvl[STAGE_NUM-1].dout_valid;
    assign tree_last  = g_lvl[STAGE_NUM-1].dout_last;
    assign tree_sum   = g_lvl[STAGE_NUM-1].dout[0];

    always_comb begin
        if (SIGNED != 0) begin
            sum_ext = ACC_WIDTH'($signed(tree_sum));
        end else begin
            sum_ext = ACC_WIDTH'(tree_sum);
        end
        total = (first_q ? '0 : acc_q) + sum_ext;
    end

    // A closing beat loads res while the old one is consumed, so out_valid can stay high.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else if (advance) begin
            if (tree_valid) begin
                if (tree_last) begin
                    res_q       <= total;
                    out_valid_q <= 1'b1;
                    first_q     <= 1'b1;
                    acc_q       <= '0;
                end else begin
                    acc_q       <= total;
                    first_q     <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign res       = res_q;

endmodule

// File: doc/pipelined_adder_tree.md
Name: pipelined_adder_tree

Overview:
- Fully pipelined, parametrised reduction tree: sums INPUT_NUM operands per beat with full-precision width growth.
- Optionally accumulates consecutive beats into one result, for multi-channel or multi-kernel-row partial sums.
- Sits between the PE multiplier array and the output/writeback stage of the convolution datapath.
- Valid/ready on both sides; one global stall for the whole pipeline.

Parameters:
- WIDTH, 32, operand width in bits.
- INPUT_NUM, 8, number of operands per beat; must be >= 2, any integer (non-power-of-2 allowed); elaboration error otherwise.
- SIGNED, 1, 1 = two's-complement operands (sign-extend), 0 = unsigned (zero-extend).
- STAGE_NUM, $clog2(INPUT_NUM), derived, number of tree levels; not overridden.
- SUM_WIDTH, WIDTH+STAGE_NUM, derived, tree result width; tree can never overflow.
- ACC_WIDTH, SUM_WIDTH+8, accumulator/output width; must be >= SUM_WIDTH.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_last  input  1  beat closes the current accumulation group.
- indata  input  [INPUT_NUM-1:0][WIDTH-1:0]  operands.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- res  output  ACC_WIDTH  group sum.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: every stage valid bit 0, stage data 0, acc 0, first flag 1, out_valid 0, res 0.
  - rst mid-group discards the partial sum and all in-flight beats.
  - in_ready is 1 in the first cycle after reset deasserts.
- Global advance: advance = !out_valid || out_ready; in_ready = advance.
  - A beat is accepted when in_valid && in_ready.
  - When advance = 0, every pipeline register, acc and res hold their values.
- Tree:
  - Level 0 pads the operand set with zeros up to 2**STAGE_NUM.
  - Each level k (1..STAGE_NUM) registers pairwise sums of width WIDTH+k.
  - Extension of each operand follows SIGNED.
  - valid and last travel alongside the data through every level.
- Accumulate stage, final register, on advance with stage-STAGE_NUM valid = 1:
  - base = first ? 0 : acc; total = base + extend(sum) to ACC_WIDTH, wrapping modulo 2**ACC_WIDTH.
  - last = 0: acc <= total; first <= 0; out_valid <= 0.
  - last = 1: res <= total; out_valid <= 1; first <= 1; acc <= 0.
  - Stage valid = 0 (bubble): acc, first and res unchanged; out_valid <= 0 if out_ready is asserted.
- Latency: STAGE_NUM+1 cycles from accepted last beat to out_valid, with no stall. Throughput is 1 beat per cycle.
- A group of N beats yields exactly one result. in_last = 1 on every beat gives the plain adder-tree sum per beat.
- out_valid && !out_ready: res stable, in_ready = 0, no beat lost or duplicated.
- Simultaneous out_ready and a new last arriving: the old result is consumed and the new one loaded in the same cycle, so out_valid stays 1.

Decomposition:
- Package adder_tree_pkg holds:
  - function tree_stages(n), the ceil-log2 with a floor of 1;
  - function sum_width(w, n);
  - default constants for WIDTH and ACC_WIDTH margin.
- Sub-module adder_tree_level: one registered level.
  - Parameters IN_NUM, IN_WIDTH, SIGNED.
  - Reduces IN_NUM operands to ceil(IN_NUM/2) outputs of IN_WIDTH+1 bits; an odd operand passes through extended.
  - Has an enable and valid/last sideband.
  - Instantiated STAGE_NUM times in a generate loop.

Test Plan:
- WIDTH=8, INPUT_NUM=8, SIGNED=1, in_last=1, all inputs 127 -> res=1016 with out_valid exactly 4 cycles after acceptance; all inputs -128 -> res=-1024.
- INPUT_NUM=5, inputs 1,2,3,4,5, single beat -> res=15 after 4 cycles (STAGE_NUM=3 plus accumulate stage), confirming zero padding.
- SIGNED=0, WIDTH=8, INPUT_NUM=8, all 255 -> res=2040 (no sign extension).
- Accumulation: three back-to-back beats with sums 10, 20, 30, in_last only on the third -> exactly one out_valid, res=60; an immediate next single-beat group of sum 7 -> res=7.
- Backpressure: stream 6 single-beat groups while out_ready is held low for 5 cycles after the first result -> in_ready low, res stable throughout; all 6 results then appear in order with no loss.
- Reset mid-group: accept 2 non-last beats (sums 100, 200), assert rst for 1 cycle, then send a last beat of sum 5 -> res=5, out_valid=0 during and after reset until that result.
